// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default oversample ratio.
// Also intended for use by the transmit side.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int UART_OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Both stages reset to RESET_VAL.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, LSB first, one stop bit.
// Define UART_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
`ifdef UART_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

  rx_state_t            state, state_next;
  logic [TW-1:0]        tick_cnt, tick_cnt_next;
  logic [BW-1:0]        bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [DATA_BITS-1:0] data_next;
  logic                 valid_next, frame_err_next;
  logic                 rx_sync, rx_prev;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rx_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_prev <= 1'b1;
    else        rx_prev <= rx_sync;
  end

`ifdef UART_PARITY_EN
  logic par_bad, par_bad_next, parity_err_next;
`endif

  always_comb begin
    state_next     = state;
    tick_cnt_next  = tick_cnt;
    bit_cnt_next   = bit_cnt;
    shreg_next     = shreg;
    data_next      = data;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_next    = par_bad;
    parity_err_next = 1'b0;
`endif
    case (state)
      IDLE: begin
        // Only a real high-to-low transition starts a frame; a held-low line does not.
        if (rx_prev && !rx_sync) begin
          state_next    = START;
          tick_cnt_next = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt_next = '0;
            if (!rx_sync) begin
              state_next   = DATA;
              bit_cnt_next = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt_next = '0;
            shreg_next    = {rx_sync, shreg[DATA_BITS-1:1]};
            bit_cnt_next  = bit_cnt + 1'b1;
            if (bit_cnt == BITS_LAST) begin
`ifdef UART_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt_next = '0;
            par_bad_next  = rx_sync ^ (^shreg) ^ PARITY_ODD;
            state_next    = STOP;
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (tick_cnt == BIT_LAST) begin
            // Leave for IDLE right at mid-stop so a following start edge is not missed.
            tick_cnt_next = '0;
            state_next    = IDLE;
            if (!rx_sync) begin
              frame_err_next = 1'b1;
`ifdef UART_PARITY_EN
            end else if (par_bad) begin
              parity_err_next = 1'b1;
`endif
            end else begin
              valid_next = 1'b1;
              data_next  = shreg;
            end
          end else begin
            tick_cnt_next = tick_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_cnt_next;
      bit_cnt   <= bit_cnt_next;
      shreg     <= shreg_next;
      data      <= data_next;
      valid     <= valid_next;
      frame_err <= frame_err_next;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= par_bad_next;
      parity_err <= parity_err_next;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed cases plus random frames vs a frame-level model.
// Honours UART_PARITY_EN to send and check parity bits.
module tb_uart_rx;

  localparam int BIT_CLK = 64;  // tick every 4 clk, 16 ticks per bit

`ifdef UART_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  localparam logic [2:0] K_VALID  = 3'b100;
  localparam logic [2:0] K_FRAME  = 3'b010;
  localparam logic [2:0] K_PARITY = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       tick;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;
  logic [1:0] tdiv = 2'd0;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  logic [7:0] model_data = 8'h00;
  logic prev_pulse = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign tick = (tdiv == 2'd3);

  uart_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .rxd        (rxd),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Frame-level reference: stop bit first, then parity (ones count incl. parity bit even).
  task automatic predict(input logic [7:0] b, input logic stop_v, input logic par_v);
    exp_t e;
    if (!stop_v) begin
      e.kind = K_FRAME;
      e.data = model_data;
    end else if (PARITY_ON && (($countones(b) + int'(par_v)) % 2 != 0)) begin
      e.kind = K_PARITY;
      e.data = model_data;
    end else begin
      e.kind = K_VALID;
      e.data = b;
      model_data = b;
    end
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic v, input int clks);
    rxd = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v);
    predict(b, stop_v, par_v);
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) send_bit(b[i], BIT_CLK);
    if (PARITY_ON) send_bit(par_v, BIT_CLK);
    send_bit(stop_v, BIT_CLK);
  endtask

  task automatic idle_check(input string name);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
    chk({name, "_data"}, {24'd0, data}, {24'd0, model_data});
  endtask

  // Monitor: every pulse must match the oldest prediction.
  always @(negedge clk) begin
    logic [2:0] cur;
    exp_t e;
    if (!rst_n) begin
      prev_pulse = 1'b0;
    end else begin
      cur = {valid, frame_err, parity_err};
      if (cur != 3'b000) begin
        chk("pulse_onehot", $countones(cur), 32'd1);
        chk("pulse_single_cycle", {31'd0, prev_pulse}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got flags %b data %0h expected none", cur, data);
        end else begin
          e = exp_q.pop_front();
          $display("rx event flags=%b data=%02h (expected flags=%b data=%02h)", cur, data, e.kind, e.data);
          chk("pulse_kind", {29'd0, cur}, {29'd0, e.kind});
          chk("pulse_data", {24'd0, data}, {24'd0, e.data});
        end
      end
      prev_pulse = (cur != 3'b000);
    end
  end

  initial begin
    logic [7:0] b;
    logic       st, pb;
    int         gap;

    repeat (5) @(negedge clk);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_flags", {29'd0, valid, frame_err, parity_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    send_bit(1'b1, 2 * BIT_CLK);

    // 1: single frame 0xA5
    rxd = 1'b0;
    repeat (BIT_CLK / 2) @(negedge clk);
    chk("t1_busy_mid_start", {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    send_bit(1'b1, 2 * BIT_CLK);
    send_frame(8'hA5, 1'b1, ^8'hA5);
    send_bit(1'b1, BIT_CLK);
    idle_check("t1");
    chk("t1_data", {24'd0, data}, 32'h0000_00A5);

    // 2: back-to-back 0x00, 0xFF
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_bit(1'b1, BIT_CLK);
    idle_check("t2");

    // 3: 20-clk glitch
    send_bit(1'b0, 20);
    send_bit(1'b1, 2 * BIT_CLK);
    idle_check("t3");

    // 4: bad stop bit, then a 10-bit break
    send_frame(8'h3C, 1'b0, ^8'h3C);
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b0, BIT_CLK);
      if (i % 3 == 0) idle_check("t4_break");
    end
    send_bit(1'b1, 2 * BIT_CLK);
    idle_check("t4");

    // 5: reset in bit 4 of 0x5A, then 0x81
    b = 8'h5A;
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) send_bit(b[i], BIT_CLK);
    send_bit(b[4], 30);
    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_rst_data", {24'd0, data}, 32'd0);
    chk("t5_rst_flags", {29'd0, valid, frame_err, parity_err}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    model_data = 8'h00;
    rst_n = 1'b1;
    send_bit(1'b1, 2 * BIT_CLK);
    idle_check("t5_after_rst");
    send_frame(8'h81, 1'b1, ^8'h81);
    send_bit(1'b1, BIT_CLK);
    idle_check("t5");

`ifdef UART_PARITY_EN
    // 6: even parity good and bad
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1, BIT_CLK);
    send_frame(8'h07, 1'b1, 1'b0);
    send_bit(1'b1, BIT_CLK);
    idle_check("t6");
`endif

    // Random frames
    for (int n = 0; n < 20; n++) begin
      b   = 8'($urandom);
      st  = ($urandom_range(0, 7) != 0);
      pb  = (^b) ^ ($urandom_range(0, 5) == 0);
      gap = st ? $urandom_range(0, 2) : 1 + $urandom_range(0, 1);
      send_frame(b, st, pb);
      if (gap > 0) send_bit(1'b1, gap * BIT_CLK);
    end
    send_bit(1'b1, BIT_CLK);
    idle_check("rand");

    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
